// File: rtl/ft245_fifo_responder_pkg.sv
// ft245_pkg: shared constants and types for the FT245 synchronous-FIFO
// responder. It holds the default FIFO depths, the byte and error-vector
// types, and the index of each sticky error bit.
package ft245_pkg;

  localparam int unsigned RX_DEPTH_DFLT = 64;
  localparam int unsigned TX_DEPTH_DFLT = 64;

  localparam int unsigned ERR_W = 4;

  localparam int unsigned ERR_RD_UNDERRUN    = 0;
  localparam int unsigned ERR_WR_OVERFLOW    = 1;
  localparam int unsigned ERR_OE_RD_ORDER    = 2;
  localparam int unsigned ERR_BUS_CONTENTION = 3;

  typedef logic [7:0]       byte_t;
  typedef logic [ERR_W-1:0] err_t;

endpackage

// File: rtl/ft245_fifo_responder_if.sv
// ft245_fifo_responder_if: the FT245 handshake pins shared by the FPGA-side
// USB master and the chip-side responder. The 8-bit data bus is not part of
// this interface. It is a plain inout on the responder.
//   usb_rxf_n  : responder -> master, low = PC->FPGA byte available
//   usb_txe_n  : responder -> master, low = FPGA->PC space available
//   usb_oe_n   : master -> responder, responder drives the bus while low
//   usb_rd_n   : master -> responder, read strobe
//   usb_wr_n   : master -> responder, write strobe
//   usb_siwu_n : master -> responder, send-immediate request
interface ft245_fifo_responder_if;

  logic usb_rxf_n;
  logic usb_txe_n;
  logic usb_oe_n;
  logic usb_rd_n;
  logic usb_wr_n;
  logic usb_siwu_n;

  modport master (
    input  usb_rxf_n, usb_txe_n,
    output usb_oe_n, usb_rd_n, usb_wr_n, usb_siwu_n
  );

  modport slave (
    output usb_rxf_n, usb_txe_n,
    input  usb_oe_n, usb_rd_n, usb_wr_n, usb_siwu_n
  );

endinterface

// File: rtl/ft245_fifo_responder_fifo.sv
// ft_sync_fifo: a single-clock, show-ahead byte FIFO with an occupancy count.
//   clk, rst_n  : clock and asynchronous active-low reset
//   push_i      : write push_data_i (the caller never pushes while full)
//   pop_i       : advance the head (the caller never pops while empty)
//   head_o      : current head byte, forced to 0 while the FIFO is empty
//   count_o     : occupancy, from 0 to DEPTH
module ft_sync_fifo
  import ft245_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  byte_t                   push_data_i,
  input  logic                    pop_i,
  output byte_t                   head_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Next pointers and count. A push and a pop in the same cycle leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers. Reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array. It needs no reset because an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign count_o = count_q;

endmodule

// File: rtl/ft245_fifo_responder.sv
// ft245_fifo_responder: the device-side model of the FT232H 245 synchronous
// FIFO. It answers the FPGA USB master and exchanges bytes with a PC-side
// byte stream.
//   usb_clk_60m, sys_rst_n      : clock and asynchronous active-low reset
//   usb (slave)                 : RXF#/TXE# outputs; OE#/RD#/WR#/SIWU# inputs
//   usb_data                    : shared bus, driven with the RX head while OE# is low
//   pc_tx_data/valid/ready      : PC -> FPGA byte stream (RX FIFO push side)
//   pc_rx_data/valid/ready      : FPGA -> PC byte stream (TX FIFO pop side)
//   siwu_pulse                  : one-cycle pulse on the SIWU# falling edge
//   err, err_clr                : sticky master-side violations and their clear
module ft245_fifo_responder
  import ft245_pkg::*;
#(
  parameter int unsigned RX_DEPTH = RX_DEPTH_DFLT,
  parameter int unsigned TX_DEPTH = TX_DEPTH_DFLT
) (
  input  logic                  usb_clk_60m,
  input  logic                  sys_rst_n,
  ft245_fifo_responder_if.slave usb,
  inout  wire  [7:0]            usb_data,
  input  byte_t                 pc_tx_data,
  input  logic                  pc_tx_valid,
  output logic                  pc_tx_ready,
  output byte_t                 pc_rx_data,
  output logic                  pc_rx_valid,
  input  logic                  pc_rx_ready,
  output logic                  siwu_pulse,
  output err_t                  err,
  input  logic                  err_clr
);

  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
  localparam logic [RX_CW-1:0] RX_FULL = RX_DEPTH[RX_CW-1:0];
  localparam logic [TX_CW-1:0] TX_FULL = TX_DEPTH[TX_CW-1:0];

  logic [RX_CW-1:0] rx_count_s;
  logic [TX_CW-1:0] tx_count_s;
  byte_t            rx_head_s;
  byte_t            tx_head_s;
  logic rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
  logic rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  logic rd_req_s, wr_req_s, oe_req_s;
  err_t err_new_s, err_d, err_q;
  logic oe_q, siwu_q, siwu_pulse_q, alive_q;

  // Handshake decode. It produces the FIFO strobes and this cycle's new error bits.
  always_comb begin
    rd_req_s   = ~usb.usb_rd_n;
    wr_req_s   = ~usb.usb_wr_n;
    oe_req_s   = ~usb.usb_oe_n;
    rx_empty_s = (rx_count_s == '0);
    rx_full_s  = (rx_count_s == RX_FULL);
    tx_empty_s = (tx_count_s == '0);
    tx_full_s  = (tx_count_s == TX_FULL);
    rx_push_s  = pc_tx_valid & alive_q & ~rx_full_s;
    tx_pop_s   = pc_rx_ready & ~tx_empty_s;
    // A read counts only after OE# was already low on the previous edge.
    rx_pop_s   = rd_req_s & oe_req_s & ~oe_q & ~rx_empty_s;
    tx_push_s  = wr_req_s & ~oe_req_s & ~tx_full_s;
    err_new_s  = '0;
    err_new_s[ERR_RD_UNDERRUN]    = rd_req_s & rx_empty_s;
    err_new_s[ERR_WR_OVERFLOW]    = wr_req_s & tx_full_s;
    err_new_s[ERR_OE_RD_ORDER]    = rd_req_s & oe_q;
    err_new_s[ERR_BUS_CONTENTION] = wr_req_s & oe_req_s;
    // A fresh error beats a simultaneous clear.
    if (err_clr) begin
      err_d = err_new_s;
    end else begin
      err_d = err_q | err_new_s;
    end
  end

  // Control registers: previous OE#, SIWU# edge detect, sticky errors and the out-of-reset flag.
  always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      oe_q         <= 1'b1;
      siwu_q       <= 1'b1;
      siwu_pulse_q <= 1'b0;
      err_q        <= '0;
      alive_q      <= 1'b0;
    end else begin
      oe_q         <= usb.usb_oe_n;
      siwu_q       <= usb.usb_siwu_n;
      siwu_pulse_q <= siwu_q & ~usb.usb_siwu_n;
      err_q        <= err_d;
      alive_q      <= 1'b1;
    end
  end

  ft_sync_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk         (usb_clk_60m),
    .rst_n       (sys_rst_n),
    .push_i      (rx_push_s),
    .push_data_i (pc_tx_data),
    .pop_i       (rx_pop_s),
    .head_o      (rx_head_s),
    .count_o     (rx_count_s)
  );

  ft_sync_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk         (usb_clk_60m),
    .rst_n       (sys_rst_n),
    .push_i      (tx_push_s),
    .push_data_i (usb_data),
    .pop_i       (tx_pop_s),
    .head_o      (tx_head_s),
    .count_o     (tx_count_s)
  );

  // The bus is released as soon as reset asserts, without waiting for a clock edge.
  assign usb_data      = (oe_req_s && sys_rst_n) ? rx_head_s : 8'hzz;
  assign usb.usb_rxf_n = rx_empty_s;
  // TXE# and the PC ready stay inactive until the first edge after reset.
  assign usb.usb_txe_n = ~alive_q | tx_full_s;
  assign pc_tx_ready   = alive_q & ~rx_full_s;
  assign pc_rx_data    = tx_head_s;
  assign pc_rx_valid   = ~tx_empty_s;
  assign siwu_pulse    = siwu_pulse_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// tb_ft245_fifo_responder: a directed-vector bench for ft245_fifo_responder
// with hand-computed expected values. The shared bus has a pull-up, so a
// released bus reads 0xFF.
module tb_ft245_fifo_responder;
  import ft245_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  sys_rst_n;
  wire   [7:0] usb_data;
  logic  tb_drv;
  byte_t tb_byte;
  byte_t pc_tx_data;
  logic  pc_tx_valid, pc_tx_ready;
  byte_t pc_rx_data;
  logic  pc_rx_valid, pc_rx_ready;
  logic  siwu_pulse;
  err_t  err;
  logic  err_clr;

  int n_vec = 0;
  int n_err = 0;

  ft245_fifo_responder_if u_if ();

  pullup pu_data (usb_data);
  assign usb_data = tb_drv ? tb_byte : 8'hzz;

  ft245_fifo_responder dut (
    .usb_clk_60m (clk),
    .sys_rst_n   (sys_rst_n),
    .usb         (u_if),
    .usb_data    (usb_data),
    .pc_tx_data  (pc_tx_data),
    .pc_tx_valid (pc_tx_valid),
    .pc_tx_ready (pc_tx_ready),
    .pc_rx_data  (pc_rx_data),
    .pc_rx_valid (pc_rx_valid),
    .pc_rx_ready (pc_rx_ready),
    .siwu_pulse  (siwu_pulse),
    .err         (err),
    .err_clr     (err_clr)
  );

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    tb_drv      = 1'b0;
    tb_byte     = 8'h00;
    pc_tx_data  = 8'h00;
    pc_tx_valid = 1'b0;
    pc_rx_ready = 1'b0;
    err_clr     = 1'b0;
    u_if.usb_oe_n   = 1'b1;
    u_if.usb_rd_n   = 1'b1;
    u_if.usb_wr_n   = 1'b1;
    u_if.usb_siwu_n = 1'b1;
    #2;
    check_vec("rst_rxf_n",    8'(u_if.usb_rxf_n), 8'h01);
    check_vec("rst_txe_n",    8'(u_if.usb_txe_n), 8'h01);
    check_vec("rst_tx_ready", 8'(pc_tx_ready),    8'h00);
    check_vec("rst_rx_valid", 8'(pc_rx_valid),    8'h00);
    check_vec("rst_rx_data",  pc_rx_data,         8'h00);
    check_vec("rst_siwu",     8'(siwu_pulse),     8'h00);
    check_vec("rst_err",      8'(err),            8'h00);
    check_vec("rst_bus_z",    usb_data,           8'hFF);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    check_vec("first_txe_n",    8'(u_if.usb_txe_n), 8'h00);
    check_vec("first_tx_ready", 8'(pc_tx_ready),    8'h01);

    // RX path: three PC bytes, then an OE-then-RD burst from the master
    pc_tx_valid = 1'b1;
    pc_tx_data  = 8'h11;
    tick();
    check_vec("rxf_after_push", 8'(u_if.usb_rxf_n), 8'h00);
    pc_tx_data = 8'h22;
    tick();
    pc_tx_data = 8'h33;
    tick();
    pc_tx_valid = 1'b0;
    u_if.usb_oe_n = 1'b0;
    #1;
    check_vec("bus_head_11", usb_data, 8'h11);
    tick();
    u_if.usb_rd_n = 1'b0;
    #1;
    check_vec("bus_rd_11", usb_data, 8'h11);
    tick();
    check_vec("bus_rd_22", usb_data, 8'h22);
    check_vec("rxf_mid",   8'(u_if.usb_rxf_n), 8'h00);
    tick();
    check_vec("bus_rd_33", usb_data, 8'h33);
    tick();
    check_vec("rxf_after_last", 8'(u_if.usb_rxf_n), 8'h01);
    u_if.usb_rd_n = 1'b1;
    u_if.usb_oe_n = 1'b1;
    #1;
    check_vec("err_after_rd", 8'(err), 8'h00);
    check_vec("bus_release",  usb_data, 8'hFF);

    // TX path: fill 64 bytes, then overflow with a 65th
    tb_drv = 1'b1;
    u_if.usb_wr_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tb_byte = 8'(i);
      tick();
      if (i == 0)  check_vec("rx_valid_first", 8'(pc_rx_valid), 8'h01);
      if (i == 62) check_vec("txe_n_63",       8'(u_if.usb_txe_n), 8'h00);
    end
    check_vec("txe_n_full", 8'(u_if.usb_txe_n), 8'h01);
    check_vec("err_full",   8'(err),            8'h00);
    tb_byte = 8'h40;
    tick();
    check_vec("err_overflow", 8'(err), 8'h02);
    u_if.usb_wr_n = 1'b1;
    tb_drv = 1'b0;
    pc_rx_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check_vec("drain_data", pc_rx_data, 8'(i));
      tick();
      if (i == 0) check_vec("txe_n_after_pop", 8'(u_if.usb_txe_n), 8'h00);
    end
    check_vec("drain_empty", 8'(pc_rx_valid), 8'h00);
    pc_rx_ready = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_vec("err_clr1", 8'(err), 8'h00);

    // RD asserted together with OE: an ordering error, no pop
    pc_tx_valid = 1'b1;
    pc_tx_data  = 8'h5A;
    tick();
    pc_tx_valid = 1'b0;
    u_if.usb_oe_n = 1'b0;
    u_if.usb_rd_n = 1'b0;
    tick();
    check_vec("err_order",    8'(err),            8'h04);
    check_vec("order_no_pop", 8'(u_if.usb_rxf_n), 8'h00);
    u_if.usb_rd_n = 1'b1;
    u_if.usb_oe_n = 1'b1;
    tick();
    check_vec("err_sticky", 8'(err), 8'h04);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_vec("err_clr2", 8'(err), 8'h00);
    err_clr = 1'b1;
    u_if.usb_rd_n = 1'b0;
    tick();
    err_clr = 1'b0;
    u_if.usb_rd_n = 1'b1;
    check_vec("err_new_wins", 8'(err), 8'h04);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_vec("err_clr3", 8'(err), 8'h00);

    // WR together with OE: bus contention, write dropped
    u_if.usb_oe_n = 1'b0;
    u_if.usb_wr_n = 1'b0;
    tb_drv  = 1'b1;
    tb_byte = 8'hA5;
    tick();
    check_vec("contention_no_push", 8'(pc_rx_valid), 8'h00);
    check_vec("err_contention",     8'(err),         8'h08);
    u_if.usb_wr_n = 1'b1;
    u_if.usb_oe_n = 1'b1;
    tb_drv = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Proper read of 0x5A, then an RD into the empty FIFO
    u_if.usb_oe_n = 1'b0;
    tick();
    u_if.usb_rd_n = 1'b0;
    #1;
    check_vec("bus_5a", usb_data, 8'h5A);
    tick();
    check_vec("rxf_empty_5a", 8'(u_if.usb_rxf_n), 8'h01);
    check_vec("err_clean_rd", 8'(err),            8'h00);
    tick();
    check_vec("err_underrun", 8'(err), 8'h01);
    u_if.usb_rd_n = 1'b1;
    u_if.usb_oe_n = 1'b1;
    #1;
    check_vec("bus_z_empty", usb_data, 8'hFF);

    // SIWU# falling edge: exactly one cycle of pulse
    u_if.usb_siwu_n = 1'b0;
    #1;
    check_vec("siwu_pre", 8'(siwu_pulse), 8'h00);
    tick();
    check_vec("siwu_hi", 8'(siwu_pulse), 8'h01);
    tick();
    check_vec("siwu_lo", 8'(siwu_pulse), 8'h00);
    u_if.usb_siwu_n = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Reset in the middle of a burst with both FIFOs occupied
    tb_drv = 1'b1;
    u_if.usb_wr_n = 1'b0;
    tb_byte = 8'h77;
    tick();
    tb_byte = 8'h78;
    tick();
    u_if.usb_wr_n = 1'b1;
    tb_drv = 1'b0;
    check_vec("tx_pre_rst", 8'(pc_rx_valid), 8'h01);
    pc_tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc_tx_data = 8'h80 + 8'(i);
      tick();
    end
    pc_tx_valid = 1'b0;
    u_if.usb_oe_n = 1'b0;
    tick();
    u_if.usb_rd_n = 1'b0;
    tick();
    check_vec("bus_burst_81", usb_data, 8'h81);
    sys_rst_n = 1'b0;
    #1;
    check_vec("mid_rst_rxf_n", 8'(u_if.usb_rxf_n), 8'h01);
    check_vec("mid_rst_bus_z", usb_data,           8'hFF);
    check_vec("mid_rst_valid", 8'(pc_rx_valid),    8'h00);
    check_vec("mid_rst_txe_n", 8'(u_if.usb_txe_n), 8'h01);
    u_if.usb_rd_n = 1'b1;
    u_if.usb_oe_n = 1'b1;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    check_vec("post_rst_rxf_n", 8'(u_if.usb_rxf_n), 8'h01);
    check_vec("post_rst_valid", 8'(pc_rx_valid),    8'h00);
    check_vec("post_rst_txe_n", 8'(u_if.usb_txe_n), 8'h00);
    pc_tx_valid = 1'b1;
    pc_tx_data  = 8'hC3;
    tick();
    pc_tx_valid = 1'b0;
    u_if.usb_oe_n = 1'b0;
    #1;
    check_vec("post_rst_head", usb_data, 8'hC3);
    u_if.usb_oe_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ft245_fifo_responder.md
# ft245_fifo_responder

Synthesizable device-side model of the FT232H 245 synchronous-FIFO interface: it plays the chip, answering the FPGA-side USB read/write master on the same 8-bit bus and handshake pins. It sits between a host-side byte-stream stimulus/sink (the "PC") and the FPGA USB controller. It is used for on-chip loopback and for regression benches in place of real silicon. Two internal FIFOs carry PC→FPGA and FPGA→PC traffic. A protocol checker flags master-side violations.

## Interface
- RX_DEPTH, 64: PC→FPGA FIFO depth in bytes (power of two, ≥4)
- TX_DEPTH, 64: FPGA→PC FIFO depth in bytes (power of two, ≥4)
- usb_clk_60m  in  1  60 MHz interface clock; all logic on rising edge
- sys_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- usb_rxf_n  out  1  low = PC→FPGA data available
- usb_txe_n  out  1  low = FPGA→PC space available
- usb_oe_n  in  1  master output-enable request (responder drives bus when low)
- usb_rd_n  in  1  master read strobe
- usb_wr_n  in  1  master write strobe
- usb_siwu_n  in  1  send-immediate request
- usb_data  inout  8  shared data bus
- pc_tx_data  in  8  PC byte to send toward FPGA
- pc_tx_valid  in  1  pc_tx_data valid
- pc_tx_ready  out  1  RX FIFO not full
- pc_rx_data  out  8  byte received from FPGA (show-ahead head)
- pc_rx_valid  out  1  TX FIFO not empty
- pc_rx_ready  in  1  PC consumes pc_rx_data
- siwu_pulse  out  1  one-cycle pulse on usb_siwu_n falling edge
- err  out  4  sticky errors: [0] read underrun, [1] write overflow, [2] OE/RD order, [3] bus contention
- err_clr  in  1  synchronous clear of err

## Operation
- RX path: PC push when pc_tx_valid & pc_tx_ready. usb_rxf_n = (rx_count==0), decoded from registered count.
- usb_data driven with RX head whenever usb_oe_n==0 and sys_rst_n==1, else high-Z. Combinational from usb_oe_n; head is registered.
- Read accept at edge when usb_rd_n==0, usb_oe_n==0, oe_q==0 (OE low the previous cycle), rx_count!=0. Pops one byte; next head is on the bus the following cycle.
- usb_rd_n==0 with rx_count==0: no pop, set err[0].
- usb_rd_n==0 with oe_q==1 (RD without one cycle of prior OE): no pop, set err[2].
- TX path: usb_txe_n = (tx_count==TX_DEPTH). Write accept at edge when usb_wr_n==0, usb_oe_n==1, tx_count!=TX_DEPTH; the usb_data byte is pushed.
- usb_wr_n==0 while full: byte dropped, set err[1].
- usb_wr_n==0 and usb_oe_n==0 in the same cycle: write ignored, set err[3].
- PC pop when pc_rx_valid & pc_rx_ready.
- Simultaneous push/pop on one FIFO: count unchanged, both complete. Push while full never occurs (ready gated). Pop while empty never occurs (valid gated).
- siwu_pulse: registered edge detect of usb_siwu_n 1→0; no effect on data flow.
- err bits are sticky. If err_clr and a new error occur in the same cycle, the new error wins.

## Timing
- Reset values: usb_rxf_n=1, usb_txe_n=1, usb_data high-Z, pc_tx_ready=0, pc_rx_valid=0, pc_rx_data=0, siwu_pulse=0, err=0. Both counts are 0, pointers are 0, oe_q=1.
- First edge after reset release: usb_txe_n=0, pc_tx_ready=1.
- PC push at edge N: usb_rxf_n low after edge N, byte on bus when OE is low from cycle N+1.
- Master sequence: OE low at cycle k, RD low at k+1. One byte per cycle accepted while RD and RXF are low. The last byte empties the FIFO, and usb_rxf_n rises after that edge.
- FPGA write at edge N: pc_rx_valid high after edge N.
- Reset mid-burst: both FIFOs flush and the bus releases immediately (asynchronous).
- Pointers wrap modulo depth. Counts are $clog2(DEPTH)+1 bits wide.

## Structure
- Package ft245_pkg holds default depths and the error bit indices ERR_RD_UNDERRUN=0, ERR_WR_OVERFLOW=1, ERR_OE_RD_ORDER=2, ERR_BUS_CONTENTION=3.
- Sub-module ft_sync_fifo (parameter DEPTH, 8-bit, show-ahead, count output) is instantiated twice, for RX and TX.
- Top level contains the handshake decode, tristate, oe_q register, SIWU edge detect and error register.

## Test plan
- Reset, then PC pushes 0x11, 0x22, 0x33. Master OE at k, RD k+1..k+3 → bus shows 0x11, 0x22, 0x33 on successive cycles. usb_rxf_n high after third accept. err=0.
- Master writes 0x00..0x3F with pc_rx_ready=0 → usb_txe_n high after 64th write. A 65th write sets err[1]. pc_rx drains 0x00..0x3F in order.
- RD low with OE low in the same first cycle → no pop, err[2]=1. err_clr → err=0.
- WR and OE low together with data 0xA5 → no push (pc_rx_valid stays 0), err[3]=1.
- RD while RX empty → err[0]=1, usb_data stays high-Z when OE is high. Also: usb_siwu_n 1→0 → siwu_pulse high exactly one cycle.
- Assert sys_rst_n mid-burst with 10 bytes queued → usb_rxf_n=1 and bus high-Z immediately, counts 0 after release.
